quire_accum_param: RTL
======================

// Module: quire_accum_param
// PURPOSE
//  Parametrised posit quire: exact fixed-point accumulation of (sign, scale, fraction) terms from a posit multiplier or decoder.
//  Successor of the fixed 4-bit/es0 quire, generalised in posit width, es, depth and output mode.
//  Adds sticky NaR, saturating overflow with sticky flag, and optional one-result-per-window output.
//  Sits between posit mult/decoder and the quire-to-posit normaliser; rts/rtr stream handshake both sides.
// PARAMETERS
//  POSIT_WIDTH   8   posit width N
//  ES            0   posit exponent size
//  LOG_NB_ACCUM  10  carry-guard bits: log2 of max terms per window
//  FRAC_W        12  fraction_i width, hidden bit(s) included
//  FRAC_FB       10  fractional bits of fraction_i (10 = product of two 1.x mantissas)
//  SCALE_W       5   scale_i width, two's complement
//  OUT_MODE      0   0 = emit running sum per input; 1 = emit only at eow
//  Derived: NQMIN = 2^(ES+2)*(N-2)+1; QUIRE_W = NQMIN+LOG_NB_ACCUM; BPP = (NQMIN-1)/2 (bit index of 2^0)
// PORTS
//  clk          in   1        clock
//  rst_n        in   1        synchronous reset, active low
//  rts_i        in   1        upstream ready to send
//  rtr_o        out  1        ready to receive (registered)
//  sow_i/eow_i  in   1        start/end of accumulation window
//  fraction_i   in   FRAC_W   unsigned magnitude
//  scale_i      in   SCALE_W  signed scale
//  sign_i       in   1        1 = subtract term
//  zero_i/NaR_i in   1        term is zero / NaR
//  rtr_i        in   1        downstream ready to receive
//  rts_o        out  1        output word valid
//  sow_o/eow_o  out  1        window markers aligned with data_o
//  data_o       out  QUIRE_W  two's-complement quire
//  sign_o/zero_o out 1        data_o MSB / data_o == 0
//  NaR_o        out  1        window contains NaR (sticky)
//  ovf_o        out  1        window saturated (sticky)
// BEHAVIOUR
//  - One clock and one reset: synchronous, active-low reset on rst_n.
//  - Reset: every output 0, pipeline empty, accumulator 0, stickies 0.
//  - rtr_o is 0 during reset and 1 on the first cycle after release.
//  - process_en = rtr_i | ~rts_o. rtr_o <= process_en. Term accepted when rts_i & rtr_o & process_en.
//  - When process_en = 0, all stages hold. No data is dropped or duplicated.
//  - Stage 1 (align): term = fraction_i placed at LSB index BPP + scale_i - FRAC_FB.
//    Left-shift for positive index, right-shift for negative. Bits below bit 0 are truncated.
//    Truncation is exact for legal posit products.
//  - Stage 2 (accumulate): base = sow ? 0 : acc; acc <= base ± term (sign_i selects).
//    zero_i leaves acc = base. NaR sets NaR sticky and leaves acc unchanged.
//  - Overflow (signed add carry into the sign bit differs from carry out): saturate to
//    +(2^(QUIRE_W-1)-1) or -(2^(QUIRE_W-1)). ovf sticky set. The saturated value is held for the rest of the window.
//  - NaR and ovf stickies clear on sow. If sow and NaR arrive together, NaR=1.
//  - sow & eow on the same term: single-term window; its result emits with both markers set.
//  - Latency: 2 accepted-cycles from input to output.
//  - OUT_MODE 0: one output per accepted term; sow_o/eow_o follow input markers.
//  - OUT_MODE 1: rts_o asserts only for the eow term; sow_o = eow_o = 1 on that word. Other terms update acc silently.
//  - Bubbles (stage_clr) do not modify acc.
//  - Reset mid-window: acc, stickies and pipeline cleared; the next term must carry sow (otherwise it accumulates onto 0).
// STRUCTURE
//  - posit_defines package: function quire_width(N,ES,LOG), localparams NQMIN/BPP as functions,
//    typedef struct quire_term_t {sign, zero, NaR, sow, eow}.
//  - Sub-module: quire_align_shift (combinational signed barrel shifter, FRAC_W -> QUIRE_W).
//    The stage-1 register stays in this module.
//  - Accumulator in logic (no DSP primitive); 120-400 lines total.
// TESTING (N=8, ES=0, FRAC_W=12, FRAC_FB=10, LOG_NB_ACCUM=10: QUIRE_W=35, BPP=12)
//  - sow+eow, frac=1024, scale=0, sign=0 -> data_o=0x1000, zero_o=0, latency 2.
//  - sow frac=1024 s=0 +; eow frac=1024 s=0 sign=1 -> second output data_o=0, zero_o=1.
//  - frac=1024, scale=-12 -> data_o=1. frac=1024, scale=+12 -> data_o=2^24.
//  - LOG_NB_ACCUM=0 (QUIRE_W=25): two terms frac=1024 s=12 -> data_o=0x0FFFFFF, ovf_o=1; next sow clears ovf_o.
//  - Window with NaR_i on 2nd of 3 terms, OUT_MODE=1 -> single output, NaR_o=1, sow_o=eow_o=1.
//  - rtr_i held low 5 cycles mid-stream with random rts_i -> outputs match the golden sum; rtr_o drops one cycle after the stall.

Source files
------------

// File: rtl/quire_accum_param_pkg.sv
// posit_defines: quire geometry helpers and the per-term marker struct shared by the quire slice.
package posit_defines;

    function automatic int nqmin(input int n, input int es);
        return (1 << (es + 2)) * (n - 2) + 1;
    endfunction

    function automatic int quire_width(input int n, input int es, input int log_nb);
        return nqmin(n, es) + log_nb;
    endfunction

    // Bit index of 2^0 inside the quire.
    function automatic int bpp(input int n, input int es);
        return (nqmin(n, es) - 1) / 2;
    endfunction

    typedef struct packed {
        logic sign;
        logic zero;
        logic nar;
        logic sow;
        logic eow;
    } quire_term_t;

endpackage

// File: rtl/quire_align_shift.sv
// quire_align_shift: places an unsigned fraction at its quire bit position using a signed barrel shift.
module quire_align_shift #(
    parameter int FRAC_W  = 12,
    parameter int FRAC_FB = 10,
    parameter int SCALE_W = 5,
    parameter int QUIRE_W = 35,
    parameter int BPP     = 12
) (
    input  logic [FRAC_W-1:0]         fraction,
    input  logic signed [SCALE_W-1:0] scale,
    output logic [QUIRE_W-1:0]        term
);

    logic signed [31:0] idx;
    logic [QUIRE_W-1:0] ext;

    // Negative index shifts right, dropping bits below the quire LSB.
    always_comb begin
        idx  = 32'(scale) + 32'(BPP - FRAC_FB);
        ext  = QUIRE_W'(fraction);
        term = idx[31] ? ext >> (-idx) : ext << idx;
    end

endmodule

// File: rtl/quire_accum_param.sv
// quire_accum_param: two-stage exact posit quire accumulator with sticky NaR and saturating overflow.
module quire_accum_param
    import posit_defines::*;
#(
    parameter int POSIT_WIDTH  = 8,
    parameter int ES           = 0,
    parameter int LOG_NB_ACCUM = 10,
    parameter int FRAC_W       = 12,
    parameter int FRAC_FB      = 10,
    parameter int SCALE_W      = 5,
    parameter int OUT_MODE     = 0,
    localparam int QUIRE_W     = quire_width(POSIT_WIDTH, ES, LOG_NB_ACCUM)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rts_i,
    output logic                      rtr_o,
    input  logic                      sow_i,
    input  logic                      eow_i,
    input  logic [FRAC_W-1:0]         fraction_i,
    input  logic signed [SCALE_W-1:0] scale_i,
    input  logic                      sign_i,
    input  logic                      zero_i,
    input  logic                      NaR_i,
    input  logic                      rtr_i,
    output logic                      rts_o,
    output logic                      sow_o,
    output logic                      eow_o,
    output logic [QUIRE_W-1:0]        data_o,
    output logic                      sign_o,
    output logic                      zero_o,
    output logic                      NaR_o,
    output logic                      ovf_o
);

    localparam int BPP = bpp(POSIT_WIDTH, ES);

    logic               process_en, accept, v1, nar_q, ovf_q, zero_q, ovf_base, ovf_sum, ovf_new;
    logic [QUIRE_W-1:0] term, term1, acc, base, sat, nxt;
    logic [QUIRE_W+1:0] sum;
    quire_term_t        m1;

    assign process_en = rtr_i | ~rts_o;
    assign accept     = rts_i & rtr_o & process_en;

    quire_align_shift #(
        .FRAC_W (FRAC_W),
        .FRAC_FB(FRAC_FB),
        .SCALE_W(SCALE_W),
        .QUIRE_W(QUIRE_W),
        .BPP    (BPP)
    ) u_align (
        .fraction(fraction_i),
        .scale   (scale_i),
        .term    (term)
    );

    // Two guard bits make the sum wide enough that the top three bits disagree exactly on overflow.
    always_comb begin
        base     = m1.sow ? '0 : acc;
        ovf_base = ~m1.sow & ovf_q;
        sum      = {{2{base[QUIRE_W-1]}}, base} + (m1.sign ? -{2'b0, term1} : {2'b0, term1});
        ovf_sum  = ~((sum[QUIRE_W+1:QUIRE_W-1] == 3'b000) | (sum[QUIRE_W+1:QUIRE_W-1] == 3'b111));
        sat      = sum[QUIRE_W+1] ? {1'b1, {(QUIRE_W-1){1'b0}}} : {1'b0, {(QUIRE_W-1){1'b1}}};
        ovf_new  = ~m1.nar & ~m1.zero & ~ovf_base & ovf_sum;
        nxt      = m1.nar ? acc : (m1.zero | ovf_base) ? base : ovf_sum ? sat : sum[QUIRE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rtr_o  <= 1'b0;
            rts_o  <= 1'b0;
            v1     <= 1'b0;
            term1  <= '0;
            m1     <= '0;
            acc    <= '0;
            nar_q  <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            sow_o  <= 1'b0;
            eow_o  <= 1'b0;
        end else begin
            rtr_o <= process_en;
            if (process_en) begin
                v1 <= accept;
                if (accept) begin
                    term1 <= term;
                    m1    <= '{sign: sign_i, zero: zero_i, nar: NaR_i, sow: sow_i, eow: eow_i};
                end
                rts_o <= v1 & ((OUT_MODE == 0) | m1.eow);
                if (v1) begin
                    acc    <= nxt;
                    zero_q <= ~|nxt;
                    nar_q  <= (~m1.sow & nar_q) | m1.nar;
                    ovf_q  <= ovf_base | ovf_new;
                    sow_o  <= (OUT_MODE != 0) ? m1.eow : m1.sow;
                    eow_o  <= m1.eow;
                end
            end
        end
    end

    assign data_o = acc;
    assign sign_o = acc[QUIRE_W-1];
    assign zero_o = zero_q;
    assign NaR_o  = nar_q;
    assign ovf_o  = ovf_q;

endmodule
